// File: rtl/census_window_ctrl_if.sv
// census_window_ctrl_if: pixel handshake and window-status bundle between the pixel source and the census window controller
interface census_window_ctrl_if #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 6
);
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;
  logic              shift_en;
  logic              win_valid;
  logic [X_BITS-1:0] win_x;
  logic [Y_BITS-1:0] win_y;
  logic              eof;
  logic              sof_err;
  logic              busy;
  modport master (
    output in_valid, in_sof,
    input  in_ready, shift_en, win_valid, win_x, win_y, eof, sof_err, busy
  );
  modport slave (
    input  in_valid, in_sof,
    output in_ready, shift_en, win_valid, win_x, win_y, eof, sof_err, busy
  );
endinterface

// File: rtl/census_window_ctrl.sv
// census_window_ctrl: sequences the census line-buffer taps and flags complete windows with their centre coordinate
module census_window_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int WIN    = 5,
  parameter int X_BITS = 6,
  parameter int Y_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  census_window_ctrl_if.slave bus_io
);
  localparam int HALF = (WIN - 1) / 2;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t            state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d, wx_q, wx_d;
  logic [Y_BITS-1:0] y_q, y_d, wy_q, wy_d;
  logic              win_q, win_d, sof_err_q, sof_err_d;
  logic              accept, last_x, last_y;
  assign bus_io.in_ready  = state_q != DONE;
  assign accept           = bus_io.in_valid & bus_io.in_ready;
  assign bus_io.shift_en  = accept & (bus_io.in_sof | state_q == ACTIVE);
  assign bus_io.eof       = state_q == DONE;
  assign bus_io.busy      = state_q != IDLE;
  assign bus_io.win_valid = win_q;
  assign bus_io.win_x     = wx_q;
  assign bus_io.win_y     = wy_q;
  assign bus_io.sof_err   = sof_err_q;
  assign last_x           = x_q == X_BITS'(IMG_W - 1);
  assign last_y           = y_q == Y_BITS'(IMG_H - 1);
  // a restart pixel sits at (0,0) so it can never complete a window
  assign win_d = accept & ~bus_io.in_sof & state_q == ACTIVE & x_q >= X_BITS'(WIN - 1) & y_q >= Y_BITS'(WIN - 1);
  assign wx_d  = win_d ? x_q - X_BITS'(HALF) : wx_q;
  assign wy_d  = win_d ? y_q - Y_BITS'(HALF) : wy_q;
  // frame sequencing and raster position of the next pixel
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sof_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (accept & bus_io.in_sof) begin
        state_d = ACTIVE;
        x_d     = X_BITS'(1);
        y_d     = '0;
      end
      ACTIVE: if (accept) begin
        if (bus_io.in_sof) begin
          x_d       = X_BITS'(1);
          y_d       = '0;
          sof_err_d = 1'b1;
        end else if (last_x) begin
          x_d     = '0;
          y_d     = last_y ? '0 : y_q + Y_BITS'(1);
          state_d = last_y ? DONE : ACTIVE;
        end else begin
          x_d = x_q + X_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters and registered window/status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      win_q     <= 1'b0;
      wx_q      <= '0;
      wy_q      <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      win_q     <= win_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      sof_err_q <= sof_err_d;
    end
  end
endmodule

// File: tb/tb_census_window_ctrl.sv
// tb_census_window_ctrl: reference-model and table checks of the census window controller on an 8x6 image with a 3x3 window
module tb_census_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WN = 3;
  localparam int HF = (WN - 1) / 2;
  typedef struct {
    bit v;
    bit s;
    bit rdy;
    bit sh;
    bit bsy;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  census_window_ctrl_if #(.X_BITS(3), .Y_BITS(3)) bus ();
  census_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(WN), .X_BITS(3), .Y_BITS(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );
  int checks = 0;
  int errors = 0;
  int n, ewx, ewy;
  bit act, done, ev, eserr;
  int cnt_shift, cnt_eof;
  int q_win[$];
  int ref_q[$];
  bit s_rdy, s_sh, s_bsy;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic mreset();
    n = 0; act = 0; done = 0; ev = 0; eserr = 0; ewx = 0; ewy = 0;
  endtask

  task automatic clr();
    cnt_shift = 0; cnt_eof = 0;
    q_win.delete();
  endtask

  task automatic step(input bit v, input bit s);
    bit acc, er, es;
    int px, py;
    bus.in_valid = v;
    bus.in_sof   = s;
    #2;
    er  = !done;
    acc = v && er;
    es  = acc && (act || s);
    chk("in_ready", bus.in_ready, er);
    chk("shift_en", bus.shift_en, es);
    chk("busy", bus.busy, act || done);
    chk("eof", bus.eof, done);
    chk("win_valid", bus.win_valid, ev);
    chk("sof_err", bus.sof_err, eserr);
    chk("win_x", bus.win_x, ewx);
    chk("win_y", bus.win_y, ewy);
    s_rdy = bus.in_ready; s_sh = bus.shift_en; s_bsy = bus.busy;
    cnt_shift += int'(bus.shift_en);
    cnt_eof   += int'(bus.eof);
    if (bus.win_valid) q_win.push_back(int'(bus.win_x) * 256 + int'(bus.win_y));
    @(posedge clk);
    #1;
    ev = 0; eserr = 0;
    if (done) done = 0;
    else if (acc && s) begin
      eserr = act; act = 1; n = 1;
    end else if (acc && act) begin
      px = n % W; py = n / W;
      if (px >= WN - 1 && py >= WN - 1) begin
        ev = 1; ewx = px - HF; ewy = py - HF;
      end
      n++;
      if (n == W * H) begin
        n = 0; act = 0; done = 1;
      end
    end
  endtask

  task automatic frame(input bit tog);
    for (int i = 0; i < (tog ? 2 * W * H : W * H); i++)
      if (tog && i % 2 == 1) step(0, 0);
      else step(1, i == 0);
    step(0, 0);
    step(0, 0);
  endtask

  task automatic cmpq(input string nm);
    int bad;
    bad = (q_win.size() == ref_q.size()) ? 0 : 1;
    for (int i = 0; i < q_win.size() && i < ref_q.size(); i++)
      if (q_win[i] != ref_q[i]) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    for (int y = WN - 1; y < H; y++)
      for (int x = WN - 1; x < W; x++)
        ref_q.push_back((x - HF) * 256 + (y - HF));
    vt[0] = '{1, 0, 1, 0, 0};
    vt[1] = '{1, 0, 1, 0, 0};
    vt[2] = '{0, 0, 1, 0, 0};
    vt[3] = '{1, 1, 1, 1, 0};
    vt[4] = '{1, 0, 1, 1, 1};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    mreset();
    clr();
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) step(0, 0);
    chk("s1_shift", cnt_shift, 0);
    // continuous frame
    clr();
    frame(0);
    chk("s2_shift_cnt", cnt_shift, W * H);
    chk("s2_win_cnt", q_win.size(), (W - WN + 1) * (H - WN + 1));
    chk("s2_eof_cnt", cnt_eof, 1);
    chk("s2_first_win", q_win.size() > 0 ? q_win[0] : -1, 1 * 256 + 1);
    chk("s2_last_win", q_win.size() > 0 ? q_win[q_win.size()-1] : -1, 6 * 256 + 4);
    cmpq("s2_seq");
    // toggling valid
    clr();
    frame(1);
    cmpq("s3_seq");
    chk("s3_eof_cnt", cnt_eof, 1);
    chk("s3_shift_cnt", cnt_shift, W * H);
    // dropped pixels while idle, then a frame
    clr();
    for (int i = 0; i < 5; i++) begin
      step(vt[i].v, vt[i].s);
      chk("s4_tbl_ready", s_rdy, vt[i].rdy);
      chk("s4_tbl_shift", s_sh, vt[i].sh);
      chk("s4_tbl_busy", s_bsy, vt[i].bsy);
    end
    repeat (W * H - 2) step(1, 0);
    step(0, 0);
    step(0, 0);
    cmpq("s4_seq");
    chk("s4_eof_cnt", cnt_eof, 1);
    // restart at (3,4)
    clr();
    step(1, 1);
    repeat (4 * W + 3 - 1) step(1, 0);
    step(1, 1);
    chk("s5_sof_err", bus.sof_err, 1);
    chk("s5_no_eof", cnt_eof, 0);
    clr();
    repeat (W * H - 1) step(1, 0);
    step(0, 0);
    step(0, 0);
    cmpq("s5_seq");
    chk("s5_first_win", q_win.size() > 0 ? q_win[0] : -1, 1 * 256 + 1);
    chk("s5_eof_cnt", cnt_eof, 1);
    // async reset at (5,3)
    clr();
    step(1, 1);
    repeat (3 * W + 5 - 1) step(1, 0);
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("s6_busy", bus.busy, 0);
    chk("s6_in_ready", bus.in_ready, 1);
    chk("s6_shift", bus.shift_en, 0);
    chk("s6_win_valid", bus.win_valid, 0);
    chk("s6_eof", bus.eof, 0);
    chk("s6_sof_err", bus.sof_err, 0);
    chk("s6_win_x", bus.win_x, 0);
    chk("s6_win_y", bus.win_y, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mreset();
    clr();
    frame(0);
    cmpq("s6_seq");
    chk("s6_shift_cnt", cnt_shift, W * H);
    chk("s6_eof_cnt", cnt_eof, 1);
    // randomized traffic against the model
    clr();
    repeat (3000) step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
